// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-tick divider, raster counters, sync/display-enable
// generation delayed to line up with a registered image-memory read.
module vga_timing_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_DISP     = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_DISP     = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pclk_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       rgb_en,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISP);
  localparam logic [9:0] H_SS   = 10'(H_DISP + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_DISP + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_DISP + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS  = 10'(V_DISP);
  localparam logic [9:0] V_SS   = 10'(V_DISP + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_DISP + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_DISP + V_FP + V_SYNC + V_BP - 1);
  logic [DW-1:0] r_div;
  logic [9:0]    r_h, r_v;
  logic [7:0]    r_frame;
  logic          w_h_wrap, w_v_wrap;
  logic [2:0]    w_raw, w_dly;
  assign pclk_en     = r_div == DIV_LAST;
  assign w_h_wrap    = r_h == H_LAST;
  assign w_v_wrap    = r_v == V_LAST;
  assign h_cnt       = r_h;
  assign v_cnt       = r_v;
  assign frame_cnt   = r_frame;
  assign valid       = (r_h < H_VIS) && (r_v < V_VIS);
  assign line_start  = pclk_en && r_h == '0;
  assign frame_start = line_start && r_v == '0;
  assign w_raw       = {r_h >= H_SS && r_h < H_SE, r_v >= V_SS && r_v < V_SE, valid};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_div   <= '0;
      r_h     <= '0;
      r_v     <= '0;
      r_frame <= '0;
    end else begin
      r_div <= pclk_en ? '0 : r_div + 1'b1;
      if (pclk_en) begin
        r_h <= w_h_wrap ? '0 : r_h + 10'd1;
        if (w_h_wrap) r_v <= w_v_wrap ? '0 : r_v + 10'd1;
        if (w_h_wrap && w_v_wrap) r_frame <= r_frame + 8'd1;
      end
    end
  // Stages reset to sync-inactive / not-visible so nothing is driven before the first real tick.
  if (PIPE_DELAY == 0) begin : g_nodly
    assign w_dly = w_raw;
  end else begin : g_dly
    logic [2:0] r_pipe [PIPE_DELAY];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_pipe <= '{default: '0};
      else if (pclk_en) begin
        r_pipe[0] <= w_raw;
        for (int i = 1; i < PIPE_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
      end
    assign w_dly = r_pipe[PIPE_DELAY-1];
  end
  assign hsync  = w_dly[2] ^ ~SYNC_POL;
  assign vsync  = w_dly[1] ^ ~SYNC_POL;
  assign rgb_en = w_dly[0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a shrunken raster (15x8 ticks, 2 clk/tick).
module tb_vga_timing_gen;
  logic clk = 1'b0, rst_n = 1'b0;
  logic pclk_en, valid, hsync, vsync, rgb_en, line_start, frame_start;
  logic [9:0] h_cnt, v_cnt;
  logic [7:0] frame_cnt;
  int n_chk = 0, n_pass = 0, cyc = 0, glitch = 0, mh = 0, mv = 0;
  logic [19:0] mem_q, rgb;
  vga_timing_gen #(
    .CLK_DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .PIPE_DELAY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pclk_en(pclk_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .valid(valid), .hsync(hsync), .vsync(vsync), .rgb_en(rgb_en),
    .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) mem_q <= '0;
    else if (pclk_en) mem_q <= {v_cnt, h_cnt} + 20'd1;
  assign rgb = rgb_en ? mem_q : '0;
  always @(negedge clk) begin
    if (!rst_n && (frame_start || line_start || pclk_en)) glitch++;
    if (int'(h_cnt) > mh) mh = int'(h_cnt);
    if (int'(v_cnt) > mv) mv = int'(v_cnt);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  int hs, vs, nz, ls, fs, pe, vs_first, hs_first, rgb_first, rgb_val, c0;
  initial begin
    step(3);
    chk("rst_pclk", pclk_en, 0);
    chk("rst_h", h_cnt, 0);
    chk("rst_v", v_cnt, 0);
    chk("rst_valid", valid, 1);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_rgb_en", rgb_en, 0);
    chk("rst_line_start", line_start, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rel_c0_pclk", pclk_en, 0);
    chk("rel_c0_fs", frame_start, 0);
    step(1);
    chk("rel_c1_pclk", pclk_en, 1);
    chk("rel_c1_fs", frame_start, 1);
    chk("rel_c1_ls", line_start, 1);
    hs = 0; vs = 0; nz = 0; ls = 0; fs = 0; pe = 0;
    vs_first = -1; hs_first = -1; rgb_first = -1; rgb_val = 0; c0 = cyc;
    for (int k = 0; k < 120; k++) begin
      pe += int'(pclk_en);
      ls += int'(line_start);
      fs += int'(frame_start);
      if (!hsync) begin
        hs++;
        if (hs_first < 0) hs_first = int'(h_cnt);
      end
      if (!vsync) begin
        vs++;
        if (vs_first < 0) vs_first = int'(v_cnt) * 15 + int'(h_cnt);
      end
      if (rgb != 0) begin
        nz++;
        if (rgb_first < 0) begin
          rgb_first = int'(v_cnt) * 15 + int'(h_cnt);
          rgb_val = int'(rgb);
        end
      end
      if (k == 8) chk("rgb_en_h8", rgb_en, 1);
      if (k == 9) chk("rgb_en_h9", rgb_en, 0);
      if (k == 10) chk("hsync_h10", hsync, 1);
      if (k == 11) chk("hsync_h11", hsync, 0);
      if (k == 14) chk("hsync_h14", hsync, 1);
      if (k == 15) chk("line_period", cyc - c0, 30);
      if (k == 75) chk("vsync_l5h0", vsync, 1);
      if (k == 105) chk("vsync_l7h0", vsync, 0);
      if (k == 106) chk("vsync_l7h1", vsync, 1);
      if (k == 119) chk("last_tick_hv", {h_cnt, v_cnt}, {10'd14, 10'd7});
      step(2);
    end
    chk("ticks_per_frame", pe, 120);
    chk("lines_per_frame", ls, 8);
    chk("fs_per_frame", fs, 1);
    chk("hsync_low_ticks", hs, 24);
    chk("hsync_first_h", hs_first, 11);
    chk("vsync_low_ticks", vs, 30);
    chk("vsync_first_pos", vs_first, 76);
    chk("rgb_pixels", nz, 32);
    chk("rgb_first_pos", rgb_first, 1);
    chk("rgb_first_data", rgb_val, 1);
    chk("frame_period", cyc - c0, 240);
    chk("f1_fs", frame_start, 1);
    chk("f1_frame_cnt", frame_cnt, 1);
    step(100);
    chk("mid_hv", {h_cnt, v_cnt}, {10'd5, 10'd3});
    chk("mid_rgb_en", rgb_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_h", h_cnt, 0);
    chk("mid_rst_v", v_cnt, 0);
    chk("mid_rst_fc", frame_cnt, 0);
    chk("mid_rst_rgb_en", rgb_en, 0);
    chk("mid_rst_pclk", pclk_en, 0);
    step(3);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("mid_rel_c0_fs", frame_start, 0);
    step(1);
    chk("mid_rel_c1_fs", frame_start, 1);
    chk("mid_rel_c1_hv", {h_cnt, v_cnt}, 20'd0);
    step(240 * 255);
    chk("f255_fs", frame_start, 1);
    chk("f255_fc", frame_cnt, 255);
    step(238);
    chk("pre_wrap_hv", {h_cnt, v_cnt}, {10'd14, 10'd7});
    chk("pre_wrap_fc", frame_cnt, 255);
    step(2);
    chk("wrap_fc", frame_cnt, 0);
    chk("wrap_fs", frame_start, 1);
    chk("wrap_hv", {h_cnt, v_cnt}, 20'd0);
    chk("max_h", mh, 14);
    chk("max_v", mv, 7);
    chk("reset_glitch", glitch, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
